// File: rtl/riscv_constants.sv
// Shared encodings for the RISC-V datapath.
// - OP2_SEL   : operand-2 source select for the ALU.
// - WB_SEL    : writeback source select for the register file.
// - rf_state_t: register-file load-tracking state.
package riscv_constants;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  typedef enum logic [1:0] {
    OP2_RS2   = 2'd0,
    OP2_IMM_I = 2'd1,
    OP2_IMM_S = 2'd2,
    OP2_PC    = 2'd3
  } OP2_SEL;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } WB_SEL;

  typedef enum logic {
    RF_IDLE      = 1'b0,
    RF_WAIT_LOAD = 1'b1
  } rf_state_t;

endpackage

// File: rtl/riscv_wb_mux.sv
// Writeback source select (combinational).
// Ports:
//   wb_sel  - source select
//   alu_out - ALU result
//   pc      - PC of the writing instruction (PC+4 computed here, wraps mod 2^32)
//   imm_u   - pre-shifted U-type immediate
//   wb_data - selected writeback value; WB_MEM produces 0 (loads write later)
module riscv_wb_mux
  import riscv_constants::*;
(
  input  WB_SEL       wb_sel,
  input  logic [31:0] alu_out,
  input  logic [31:0] pc,
  input  logic [31:0] imm_u,
  output logic [31:0] wb_data
);

  always_comb begin
    wb_data = '0;
    case (wb_sel)
      WB_ALU:  wb_data = alu_out;
      WB_PC4:  wb_data = pc + 32'd4;
      WB_IMM:  wb_data = imm_u;
      default: wb_data = '0;
    endcase
  end

endmodule

// File: rtl/riscv_regfile_wb.sv
// Integer register file with writeback source selection and tracking of a
// single outstanding load.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   rs1_addr/rs2_addr        - read addresses
//   rs1_data/rs2_data        - combinational read data (array + write bypass)
//   raw_hazard               - a read hits the pending load destination
//   wb_en/wb_ready           - writeback request / accepted this cycle
//   wb_sel, rd_addr          - writeback source and destination
//   alu_out, pc, imm_u       - writeback source operands
//   load_resp_valid/ready    - load response handshake
//   load_resp_data           - load data, already extended
module riscv_regfile_wb
  import riscv_constants::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        raw_hazard,
  input  logic        wb_en,
  output logic        wb_ready,
  input  WB_SEL       wb_sel,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] alu_out,
  input  logic [31:0] pc,
  input  logic [31:0] imm_u,
  input  logic        load_resp_valid,
  output logic        load_resp_ready,
  input  logic [31:0] load_resp_data
);

  logic [31:0] regs [NREGS];
  rf_state_t   state, state_nxt;
  logic [4:0]  pend_rd;
  logic [31:0] wb_data;

  logic wb_fire, issue, load_fire, alu_we, ld_we;

  riscv_wb_mux u_wb_mux (
    .wb_sel  (wb_sel),
    .alu_out (alu_out),
    .pc      (pc),
    .imm_u   (imm_u),
    .wb_data (wb_data)
  );

  // Gating with rst keeps a reset cycle from committing writes or
  // bypassing them onto the read ports.
  assign wb_fire   = wb_en && wb_ready && !rst;
  assign issue     = wb_fire && (wb_sel == WB_MEM);
  assign load_fire = load_resp_valid && load_resp_ready && !rst;
  assign alu_we    = wb_fire && (wb_sel != WB_MEM) && (rd_addr != '0);
  assign ld_we     = load_fire && (pend_rd != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RF_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RF_IDLE:      if (issue)     state_nxt = RF_WAIT_LOAD;
      RF_WAIT_LOAD: if (load_fire) state_nxt = RF_IDLE;
      default:      state_nxt = RF_IDLE;
    endcase
  end

  // Outputs: only one load in flight, and no younger write may overtake
  // the pending load to the same (nonzero) register.
  always_comb begin
    wb_ready        = 1'b1;
    load_resp_ready = 1'b0;
    if (state == RF_WAIT_LOAD) begin
      load_resp_ready = 1'b1;
      if (wb_sel == WB_MEM)                         wb_ready = 1'b0;
      else if ((rd_addr == pend_rd) && (pend_rd != '0)) wb_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        pend_rd <= '0;
    else if (issue) pend_rd <= rd_addr;
  end

  // Two write ports; the WAW block guarantees they never share a target.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i[4:0]] <= (i == 2) ? SP_INIT : '0;
    end else begin
      if (alu_we) regs[rd_addr] <= wb_data;
      if (ld_we)  regs[pend_rd] <= load_resp_data;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] a);
    logic [31:0] v;
    v = regs[a];
    if (a == '0)                      v = '0;
    else if (ld_we && (a == pend_rd)) v = load_resp_data;
    else if (alu_we && (a == rd_addr)) v = wb_data;
    return v;
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

  assign raw_hazard = (state == RF_WAIT_LOAD) && (pend_rd != '0) &&
                      ((rs1_addr == pend_rd) || (rs2_addr == pend_rd)) &&
                      !load_resp_valid;

endmodule

// File: tb/tb_riscv_regfile_wb.sv
module tb_riscv_regfile_wb;
  import riscv_constants::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        raw_hazard, wb_en, wb_ready;
  WB_SEL       wb_sel;
  logic [31:0] alu_out, pc, imm_u;
  logic        load_resp_valid, load_resp_ready;
  logic [31:0] load_resp_data;

  int checks = 0;
  int errors = 0;

  riscv_regfile_wb #(.SP_INIT(32'h0000_8000)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .raw_hazard      (raw_hazard),
    .wb_en           (wb_en),
    .wb_ready        (wb_ready),
    .wb_sel          (wb_sel),
    .rd_addr         (rd_addr),
    .alu_out         (alu_out),
    .pc              (pc),
    .imm_u           (imm_u),
    .load_resp_valid (load_resp_valid),
    .load_resp_ready (load_resp_ready),
    .load_resp_data  (load_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    WB_SEL       sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pcv;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } sb_t;

  vec_t vecs [7];
  sb_t  sb [$];
  sb_t  e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{WB_ALU, 5'd5,  32'hDEAD_BEEF, 32'h0,         32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{WB_ALU, 5'd0,  32'h0000_1234, 32'h0,         32'h0,         32'h0};
    vecs[2] = '{WB_ALU, 5'd1,  32'h0000_0111, 32'h0,         32'h0,         32'h0000_0111};
    vecs[3] = '{WB_PC4, 5'd1,  32'hBAD0_BAD0, 32'hFFFF_FFFC, 32'h1111_0000, 32'h0};
    vecs[4] = '{WB_IMM, 5'd3,  32'hBAD0_BAD0, 32'h0000_0040, 32'hABCD_E000, 32'hABCD_E000};
    vecs[5] = '{WB_PC4, 5'd4,  32'h0,         32'h0000_1000, 32'h0,         32'h0000_1004};
    vecs[6] = '{WB_ALU, 5'd31, 32'hA5A5_5A5A, 32'h0000_2000, 32'h7777_0000, 32'hA5A5_5A5A};

    rst = 1'b1; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    wb_en = 1'b0; wb_sel = WB_ALU; alu_out = '0; pc = '0; imm_u = '0;
    load_resp_valid = 1'b0; load_resp_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_wb_ready", {31'b0, wb_ready}, 32'd1);
    chk("rst_lrr", {31'b0, load_resp_ready}, 32'd0);
    chk("rst_raw", {31'b0, raw_hazard}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = i[4:0];
      #1;
      chk($sformatf("rst_x%0d", i), rs1_data, (i == 2) ? 32'h0000_8000 : 32'h0);
    end

    // Table-driven writes: bypass same cycle, array readback next cycle
    foreach (vecs[k]) begin
      wb_en = 1'b1; wb_sel = vecs[k].sel; rd_addr = vecs[k].rd;
      alu_out = vecs[k].alu; pc = vecs[k].pcv; imm_u = vecs[k].imm;
      rs1_addr = vecs[k].rd;
      #1;
      chk($sformatf("v%0d_ready", k), {31'b0, wb_ready}, 32'd1);
      chk($sformatf("v%0d_bypass", k), rs1_data, vecs[k].exp);
      sb.push_back('{vecs[k].rd, vecs[k].exp});
      tick();
      wb_en = 1'b0;
      e = sb.pop_front();
      rs2_addr = e.addr;
      #1;
      chk($sformatf("v%0d_rd2", k), rs2_data, e.data);
      chk($sformatf("v%0d_rd1_next", k), rs1_data, e.data);
    end

    // Load to x7 with held-off response
    wb_en = 1'b1; wb_sel = WB_MEM; rd_addr = 5'd7;
    #1;
    chk("ld_issue_ready", {31'b0, wb_ready}, 32'd1);
    chk("ld_issue_lrr", {31'b0, load_resp_ready}, 32'd0);
    tick();
    wb_en = 1'b0; rs2_addr = 5'd7; rs1_addr = 5'd0;
    #1;
    chk("ld_raw", {31'b0, raw_hazard}, 32'd1);
    chk("ld_lrr", {31'b0, load_resp_ready}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("ld_raw_hold%0d", c), {31'b0, raw_hazard}, 32'd1);
    end
    // Request checks in WAIT_LOAD (wb_en low so nothing commits)
    wb_sel = WB_ALU; rd_addr = 5'd7; #1;
    chk("waw_block", {31'b0, wb_ready}, 32'd0);
    wb_sel = WB_MEM; rd_addr = 5'd9; #1;
    chk("mem_block", {31'b0, wb_ready}, 32'd0);
    wb_sel = WB_ALU; rd_addr = 5'd8; #1;
    chk("alu_other_ok", {31'b0, wb_ready}, 32'd1);
    // IDLE response must not be needed; now respond alongside an ALU write
    wb_en = 1'b1; alu_out = 32'h0000_8888;
    load_resp_valid = 1'b1; load_resp_data = 32'h5555_AAAA;
    rs1_addr = 5'd8;
    #1;
    chk("resp_raw", {31'b0, raw_hazard}, 32'd0);
    chk("resp_byp7", rs2_data, 32'h5555_AAAA);
    chk("resp_byp8", rs1_data, 32'h0000_8888);
    tick();
    wb_en = 1'b0; load_resp_valid = 1'b0;
    wb_sel = WB_MEM;
    #1;
    chk("post_lrr", {31'b0, load_resp_ready}, 32'd0);
    chk("post_ready", {31'b0, wb_ready}, 32'd1);
    chk("post_x7", rs2_data, 32'h5555_AAAA);
    chk("post_x8", rs1_data, 32'h0000_8888);

    // Response while IDLE is ignored
    load_resp_valid = 1'b1; load_resp_data = 32'h0000_0077;
    tick();
    load_resp_valid = 1'b0;
    #1;
    chk("idle_resp_x7", rs2_data, 32'h5555_AAAA);
    chk("idle_resp_lrr", {31'b0, load_resp_ready}, 32'd0);

    // Load to x0: enters WAIT, no hazard, data discarded
    wb_en = 1'b1; wb_sel = WB_MEM; rd_addr = 5'd0;
    tick();
    wb_en = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    chk("x0_lrr", {31'b0, load_resp_ready}, 32'd1);
    chk("x0_raw", {31'b0, raw_hazard}, 32'd0);
    load_resp_valid = 1'b1; load_resp_data = 32'hCAFE_F00D;
    #1;
    chk("x0_byp", rs1_data, 32'h0);
    tick();
    load_resp_valid = 1'b0;
    #1;
    chk("x0_read", rs1_data, 32'h0);
    chk("x0_idle", {31'b0, load_resp_ready}, 32'd0);

    // Reset during WAIT_LOAD drops the load
    wb_en = 1'b1; wb_sel = WB_MEM; rd_addr = 5'd10;
    tick();
    wb_en = 1'b0; rs1_addr = 5'd10;
    #1;
    chk("r_wait_raw", {31'b0, raw_hazard}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("r_lrr", {31'b0, load_resp_ready}, 32'd0);
    chk("r_ready", {31'b0, wb_ready}, 32'd1);
    chk("r_raw", {31'b0, raw_hazard}, 32'd0);
    load_resp_valid = 1'b1; load_resp_data = 32'hFFFF_FFFF;
    #1;
    chk("r_resp_byp", rs1_data, 32'h0);
    tick();
    load_resp_valid = 1'b0;
    rs2_addr = 5'd5;
    #1;
    chk("r_x10", rs1_data, 32'h0);
    chk("r_x5", rs2_data, 32'h0);
    chk("r_lrr2", {31'b0, load_resp_ready}, 32'd0);
    rs2_addr = 5'd2;
    #1;
    chk("r_x2", rs2_data, 32'h0000_8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
